// File: rtl/reg_alu_ctrl_if.sv
// ---------------------------------------------------------------------------
// reg_alu_ctrl_if
// Instruction handshake between an instruction source and reg_alu_ctrl.
//   instr        16-bit instruction word (source -> controller)
//   instr_valid  instr is valid this cycle (source -> controller)
//   instr_ready  controller accepts instr this cycle (controller -> source)
// The source holds instr/instr_valid until a cycle with instr_ready=1.
// ---------------------------------------------------------------------------
interface reg_alu_ctrl_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output instr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/reg_alu_ctrl.sv
// ---------------------------------------------------------------------------
// reg_alu_ctrl
// Instruction-sequencing controller for the reg_alu datapath. Each accepted
// 16-bit instruction is latched into the instruction register (IR) and
// expanded into datapath cycles:
//   LOADI (00): accept -> EXEC_WR                  (2 cycles)
//   ALU   (01): accept -> EXEC_RD -> EXEC_WR       (3 cycles)
//   NOP   (10): accept only, stays in IDLE         (1 cycle)
//   HALT  (11): accept -> HALT, left only by reset
// Ports:
//   clk, reset    clock and synchronous active-high reset
//   bus           instruction handshake (slave side)
//   cout          carry out of reg_alu, captured on ALU writes
//   sel, wr, op   reg_alu controls (sel: 0 = d_in, 1 = ALU result)
//   rd_addr_a/b   register-file read addresses
//   wr_addr       register-file write address
//   d_in          zero-extended LOADI immediate
//   carry_flag    cout latched at the last ALU write
//   instr_count   retired-instruction counter (wraps silently)
//   halted        HALT has been executed
// ---------------------------------------------------------------------------
module reg_alu_ctrl (
    input  logic          clk,
    input  logic          reset,
    reg_alu_ctrl_if.slave bus,
    input  logic          cout,
    output logic          sel,
    output logic          wr,
    output logic [1:0]    op,
    output logic [2:0]    rd_addr_a,
    output logic [2:0]    rd_addr_b,
    output logic [2:0]    wr_addr,
    output logic [15:0]   d_in,
    output logic          carry_flag,
    output logic [7:0]    instr_count,
    output logic          halted
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_EXEC_RD = 2'b01,
        S_EXEC_WR = 2'b10,
        S_HALT    = 2'b11
    } state_t;

    localparam logic [1:0] CLS_LOADI = 2'b00;
    localparam logic [1:0] CLS_ALU   = 2'b01;
    localparam logic [1:0] CLS_NOP   = 2'b10;
    localparam logic [1:0] CLS_HALT  = 2'b11;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        carry_q, carry_d;
    logic [7:0]  count_q, count_d;
    logic        halted_q, halted_d;
    logic        ready;
    logic        wr_en;

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        carry_d  = carry_q;
        count_d  = count_q;
        halted_d = halted_q;
        ready    = 1'b0;
        wr_en    = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (bus.instr_valid) begin
                    ir_d = bus.instr;
                    case (bus.instr[15:14])
                        CLS_LOADI: state_d = S_EXEC_WR;
                        CLS_ALU:   state_d = S_EXEC_RD;
                        CLS_NOP:   count_d = count_q + 8'd1;
                        CLS_HALT: begin
                            state_d  = S_HALT;
                            halted_d = 1'b1;
                            count_d  = count_q + 8'd1;
                        end
                        default:   state_d = S_IDLE;
                    endcase
                end
            end
            S_EXEC_RD: state_d = S_EXEC_WR;
            S_EXEC_WR: begin
                wr_en   = 1'b1;
                count_d = count_q + 8'd1;
                // LOADI does not touch the ALU, so its write keeps the old carry.
                if (ir_q[15:14] == CLS_ALU) begin
                    carry_d = cout;
                end
                state_d = S_IDLE;
            end
            S_HALT: halted_d = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // Reset masks the handshake and the write strobe in the same cycle,
        // so an instruction in flight is aborted without touching the regfile.
        if (reset) begin
            ready = 1'b0;
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ir_q     <= 16'd0;
            carry_q  <= 1'b0;
            count_q  <= 8'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            carry_q  <= carry_d;
            count_q  <= count_d;
            halted_q <= halted_d;
        end
    end

    // Datapath fields decode from the IR in every state; only wr qualifies them.
    assign bus.instr_ready = ready;
    assign wr          = wr_en;
    assign sel         = (ir_q[15:14] == CLS_ALU);
    assign op          = ir_q[13:12];
    assign rd_addr_a   = ir_q[11:9];
    assign rd_addr_b   = ir_q[8:6];
    assign wr_addr     = (ir_q[15:14] == CLS_LOADI) ? ir_q[13:11] : ir_q[5:3];
    assign d_in        = {5'b0, ir_q[10:0]};
    assign carry_flag  = carry_q;
    assign instr_count = count_q;
    assign halted      = halted_q;
endmodule
